// File: rtl/param_match_counter.sv
// Up/down counter stepped by a free-run enable or a debounced push-button press,
// with synchronous load, terminal-count pulse and compare-match level/pulse outputs.
module param_match_counter #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SATURATE        = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] cmp_val,
   output logic [WIDTH-1:0] count,
   output logic             match,
   output logic             match_pulse,
   output logic             tc,
   output logic             btn_step
);

   localparam int                STAB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [STAB_W-1:0] STAB_ZERO = {STAB_W{1'b0}};
   localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0]  CNT_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};

   logic              sync1_r;
   logic              sync2_r;
   logic              db_r;
   logic              db_d_r;
   logic [STAB_W-1:0] stab_r;
   logic              btn_step_r;
   logic [WIDTH-1:0]  count_r;
   logic              tc_r;
   logic              match_hist_r;

   logic              step_s;
   logic              at_bound_s;
   logic              match_s;
   logic [WIDTH-1:0]  step_val_s;
   logic [WIDTH-1:0]  next_count_s;

   // Synchroniser, stability-qualified debounce and one-shot press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r    <= 1'b0;
         sync2_r    <= 1'b0;
         db_r       <= 1'b0;
         db_d_r     <= 1'b0;
         stab_r     <= STAB_ZERO;
         btn_step_r <= 1'b0;
      end else begin
         sync1_r    <= btn;
         sync2_r    <= sync1_r;
         db_d_r     <= db_r;
         btn_step_r <= db_r & ~db_d_r;
         if (sync2_r != db_r) begin
            if (stab_r == STAB_LAST) begin
               db_r   <= sync2_r;
               stab_r <= STAB_ZERO;
            end else begin
               db_r   <= db_r;
               stab_r <= stab_r + STAB_ONE;
            end
         end else begin
            db_r   <= db_r;
            stab_r <= STAB_ZERO;
         end
      end
   end

   // Step decode: next value, boundary detection and saturation hold.
   always_comb begin
      step_s  = en | btn_step_r;
      match_s = (count_r == cmp_val);
      if (up_dn) begin
         at_bound_s = (count_r == CNT_MAX);
         step_val_s = count_r + CNT_ONE;
      end else begin
         at_bound_s = (count_r == CNT_ZERO);
         step_val_s = count_r - CNT_ONE;
      end
      if (at_bound_s && (SATURATE != 0)) begin
         next_count_s = count_r;
      end else begin
         next_count_s = step_val_s;
      end
   end

   // Counter state with load > step > hold priority; tc flags only boundary steps.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r      <= CNT_ZERO;
         tc_r         <= 1'b0;
         match_hist_r <= 1'b0;
      end else begin
         match_hist_r <= match_s;
         if (load) begin
            count_r <= load_val;
            tc_r    <= 1'b0;
         end else if (step_s) begin
            count_r <= next_count_s;
            tc_r    <= at_bound_s;
         end else begin
            count_r <= count_r;
            tc_r    <= 1'b0;
         end
      end
   end

   assign count       = count_r;
   assign tc          = tc_r;
   assign btn_step    = btn_step_r;
   assign match       = match_s;
   assign match_pulse = match_s & ~match_hist_r;

endmodule

// File: tb/tb_param_match_counter.sv
// Scoreboard bench: each vector pushes the outputs expected while it is applied;
// a negedge monitor pops and compares against a wrapping and a saturating instance.
module tb_param_match_counter;

   logic       clk;
   logic       rst;
   logic       btn;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] cmp_val;

   logic [7:0] count0, count1;
   logic       match0, match1, mp0, mp1, tc0, tc1, bs0, bs1;

   typedef struct {
      string      nm;
      logic [6:0] mk;
      logic [7:0] c0;
      logic       tc0;
      logic       m;
      logic       mp;
      logic       bs;
      logic [7:0] c1;
      logic       tc1;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [6:0] ALL = 7'b1111111;
   localparam logic [6:0] CT  = 7'b1110011;

   param_match_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(0)) dut0 (
      .clk(clk), .rst(rst), .btn(btn), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cmp_val(cmp_val), .count(count0), .match(match0),
      .match_pulse(mp0), .tc(tc0), .btn_step(bs0)
   );

   param_match_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(1)) dut1 (
      .clk(clk), .rst(rst), .btn(btn), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cmp_val(cmp_val), .count(count1), .match(match1),
      .match_pulse(mp1), .tc(tc1), .btn_step(bs1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h, expected %h at %0t", nm, fld, act, exp, $time);
      end
   endtask

   // Monitor: every negedge, compare the DUT outputs with the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.mk[0]) chk(e.nm, "count0", count0, e.c0);
            if (e.mk[1]) chk(e.nm, "tc0", {7'd0, tc0}, {7'd0, e.tc0});
            if (e.mk[2]) chk(e.nm, "match", {7'd0, match0}, {7'd0, e.m});
            if (e.mk[3]) chk(e.nm, "match_pulse", {7'd0, mp0}, {7'd0, e.mp});
            if (e.mk[4]) chk(e.nm, "btn_step0", {7'd0, bs0}, {7'd0, e.bs});
            if (e.mk[4]) chk(e.nm, "btn_step1", {7'd0, bs1}, {7'd0, e.bs});
            if (e.mk[5]) chk(e.nm, "count1", count1, e.c1);
            if (e.mk[6]) chk(e.nm, "tc1", {7'd0, tc1}, {7'd0, e.tc1});
         end
      end
   end

   task automatic vec(input string nm, input logic r, input logic e, input logic u, input logic l,
                      input logic [7:0] lv, input logic [7:0] cv, input logic b, input logic [6:0] mk,
                      input logic [7:0] ec0, input logic etc0, input logic em, input logic emp,
                      input logic ebs, input logic [7:0] ec1, input logic etc1);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; en = e; up_dn = u; load = l; load_val = lv; cmp_val = cv; btn = b;
      x.nm = nm; x.mk = mk; x.c0 = ec0; x.tc0 = etc0; x.m = em; x.mp = emp;
      x.bs = ebs; x.c1 = ec1; x.tc1 = etc1;
      q.push_back(x);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; btn = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
      load_val = 8'h00; cmp_val = 8'h00;

      // reset state and first-cycle match pulse
      vec("rst_hold",    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      vec("rst_release", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      // up-count across all-ones boundary
      vec("load_fe",     1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 8'h80, 1'b0, ALL, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      vec("inc_fe",      1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0);
      vec("inc_ff",      1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
      vec("wrap_up",     1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
      vec("after_wrap",  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
      // down-count across zero
      vec("load_01",     1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 1'b0, ALL, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
      vec("dec_01",      1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
      vec("dec_00",      1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      vec("dec_bound1",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      vec("dec_bound2",  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, ALL, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      // load beats step; match level and pulse
      vec("load_5a_en",  1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, ALL, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      vec("match_rise",  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, ALL, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
      vec("reload_5a",   1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, ALL, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
      vec("reload_none", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, ALL, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
      vec("cmp_away",    1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, ALL, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
      vec("cmp_back",    1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, ALL, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
      vec("cmp_hold",    1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, ALL, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
      // reset in the middle of counting
      vec("load_31",     1'b0, 1'b0, 1'b1, 1'b1, 8'h31, 8'h00, 1'b0, ALL, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
      vec("cnt_31",      1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31, 1'b0);
      vec("cnt_32",      1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h32, 1'b0);
      vec("rst_at_33",   1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0);
      vec("post_rst",    1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      vec("resume_01",   1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
      vec("resume_02",   1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ALL, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
      // push-button: short glitch, long press with coincident enable, release, second press
      vec("load_10",     1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0, CT,  8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
      for (int i = 0; i < 9; i++)
         vec("glitch", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, (i < 3), CT, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
      for (int i = 0; i < 20; i++)
         vec("press1", 1'b0, (i == 7), 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT, (i <= 7) ? 8'h10 : 8'h11,
             1'b0, 1'b0, 1'b0, (i == 7), (i <= 7) ? 8'h10 : 8'h11, 1'b0);
      for (int i = 0; i < 10; i++)
         vec("release1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, CT, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
      for (int i = 0; i < 10; i++)
         vec("press2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT, (i <= 7) ? 8'h11 : 8'h12,
             1'b0, 1'b0, 1'b0, (i == 7), (i <= 7) ? 8'h11 : 8'h12, 1'b0);
      // reset while held, then reset mid-debounce
      vec("rst_held",    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT,  8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0);
      for (int i = 0; i < 10; i++)
         vec("requal", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT, (i <= 7) ? 8'h00 : 8'h01,
             1'b0, 1'b0, 1'b0, (i == 7), (i <= 7) ? 8'h00 : 8'h01, 1'b0);
      for (int i = 0; i < 10; i++)
         vec("release2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, CT, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
      for (int i = 0; i < 4; i++)
         vec("part_press", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
      vec("rst_mid_db",  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT,  8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
      for (int i = 0; i < 10; i++)
         vec("requal2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, CT, (i <= 7) ? 8'h00 : 8'h01,
             1'b0, 1'b0, 1'b0, (i == 7), (i <= 7) ? 8'h00 : 8'h01, 1'b0);

      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         if (q.size() == 0) break;
      end
      @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
